// File: rtl/read_arbiter_pkg.sv
// Shared types and defaults for the read_arbiter slice: FSM state encoding,
// parameter defaults and a one-hot to index helper.
package read_arbiter_pkg;

    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // OR-reduction encoder: valid for any one-hot (or zero) input up to 8 bits.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after i_ptr,
// searching cyclically, returned one-hot with a valid flag.
module rr_pick
    import read_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_win,
    output logic                    o_valid
);
    localparam int PW = $clog2(NREQ);

    logic [PW:0] w_sum;
    logic        w_found;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
        o_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
            if (!w_found && i_req[w_sum[PW-1:0]]) begin
                o_win[w_sum[PW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/read_arbiter.sv
// Round-robin arbiter granting one requester at a time to a shared read engine.
// Optional WAIT watchdog enabled by defining READ_ARBITER_TIMEOUT_EN.
module read_arbiter
    import read_arbiter_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [NREQ-1:0] o_done,
    output logic            o_start,
    input  logic            i_ds,
    output logic            o_err
);
    localparam int PW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_next;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_start;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] w_win;
    logic            w_valid;
    logic            w_timeout;
    logic [PW-1:0]   w_owner;
    logic [PW-1:0]   w_ptr_next;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_owner    = PW'(onehot_to_idx(8'(r_gnt)));
    assign w_ptr_next = (w_owner == PW'(NREQ-1)) ? '0 : w_owner + PW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_valid) w_next = ST_ISSUE;
            ST_ISSUE:   w_next = ST_WAIT;
            ST_WAIT:    if (i_ds || w_timeout) w_next = ST_RELEASE;
            ST_RELEASE: w_next = ST_IDLE;
            default:    w_next = state_t'('x);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            r_ptr   <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values, whatever the statement order.
            r_state <= w_next;
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                ST_IDLE: if (w_valid) begin
                    r_gnt   <= w_win;
                    r_start <= 1'b1;
                end
                ST_WAIT: if (i_ds) r_done <= r_gnt;
                ST_RELEASE: begin
                    r_gnt <= '0;
                    r_ptr <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

`ifdef READ_ARBITER_TIMEOUT_EN
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WW-1:0] r_wd;
    logic          r_err;

    // Abort on the WAIT cycle whose increment would bring the count to TIMEOUT-1.
    assign w_timeout = (r_state == ST_WAIT) && (r_wd == WW'(TIMEOUT-2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout && !i_ds;
            if (r_state == ST_ISSUE)
                r_wd <= '0;
            else if (r_state == ST_WAIT && !i_ds)
                r_wd <= r_wd + WW'(1);
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign o_gnt   = r_gnt;
    assign o_done  = r_done;
    assign o_start = r_start;

endmodule
